testdrive_interrupt_gen: RTL and testbench
==========================================

// Module: testdrive_interrupt_gen
// PURPOSE
//  Interrupt source for the DUT side of the testdrive_interrupt_bfm link: collects per-source event
//  pulses into raw pending bits, applies an enable mask, coalesces by count/timeout and drives INTR.
//  Sits in the DUT top; INTR wires straight to the interrupt BFM's INTR input. Host services via
//  write-1-to-clear ACK and reads PENDING/OVF. Format matches BFM: C_PULSE_MODE=1 <-> C_EDGE_DETECT=1.
// PARAMETERS
//  C_SOURCES       8       number of event sources (1..32)
//  C_COALESCE      1       enabled new events needed before firing (1..255)
//  C_TIMEOUT       0       cycles after first enabled pending before forced fire; 0 = disabled (<2^16)
//  C_PULSE_MODE    0       0 = level INTR held until serviced; 1 = INTR pulse of C_PULSE_WIDTH cycles
//  C_PULSE_WIDTH   1       pulse length in cycles (1..15), pulse mode only
//  C_MASK_RESET    all 1s  MASK value after reset
// PORTS
//  CLK        in   1          system clock
//  RST        in   1          synchronous, active-high reset
//  EVENT      in   C_SOURCES  per-source event; bit high in a cycle = one event
//  MASK_WE    in   1          load MASK from MASK_WDATA
//  MASK_WDATA in   C_SOURCES  new enable mask (1 = enabled)
//  ACK_EN     in   1          service strobe
//  ACK_DATA   in   C_SOURCES  write-1-to-clear pattern for PENDING and OVF
//  MASK       out  C_SOURCES  current enable mask
//  PENDING    out  C_SOURCES  raw pending bits (set regardless of mask)
//  OVF        out  C_SOURCES  event arrived while bit already pending
//  INTR       out  1          interrupt to BFM, active high, registered
// BEHAVIOUR
//  Reset: PENDING=0, OVF=0, MASK=C_MASK_RESET, INTR=0, count=0, timer=0, state=IDLE; next edge wins mid-op.
//  Pending: at edge, PENDING[i] <= (PENDING[i] & ~(ACK_EN&ACK_DATA[i])) | EVENT[i]; set beats clear.
//  OVF[i] set when EVENT[i] & PENDING[i] & ~(ACK_EN&ACK_DATA[i]); cleared only by ACK bit i.
//  new = EVENT & ~PENDING & MASK (pending-to-be-cleared counts as not pending for new); count +=
//   popcount(new), saturates at C_COALESCE. Unmasking an already-pending bit does not bump count.
//  epend = PENDING & MASK (registered values). All FSM decisions use registered state/count/epend.
//  FSM: IDLE: count>=C_COALESCE -> FIRE; else epend!=0 -> GATHER (timer=0).
//   GATHER: timer++ each cycle; count>=C_COALESCE or (C_TIMEOUT!=0 and timer==C_TIMEOUT-1) -> FIRE;
//    epend==0 (host polled) -> IDLE.
//   FIRE: INTR<=1. Level: stay until epend==0 -> IDLE. Pulse: leave after C_PULSE_WIDTH cycles
//    -> WAIT_CLR (or IDLE if epend==0).
//   WAIT_CLR: INTR<=0; epend==0 -> IDLE. Events here set PENDING, are counted, no re-fire until IDLE.
//  Entering IDLE clears count and timer; events arriving in that same cycle are still counted.
//  Latency: EVENT at edge k -> PENDING at k; C_COALESCE=1 -> INTR high after edge k+1.
//  Masking all pending bits during FIRE -> epend==0 -> INTR drops next edge (level) / after pulse.
//  INTR is a flop output; no combinational path from any input.
// TESTING
//  1 level, COALESCE=1: EVENT=0x01 one cycle -> PENDING=0x01 next, INTR=1 one cycle later;
//    ACK 0x01 -> INTR=0 within 2 cycles.
//  2 COALESCE=4, TIMEOUT=0: three single events -> no INTR; fourth -> INTR; EVENT=0x0F in one
//    cycle also fires (popcount).
//  3 COALESCE=8, TIMEOUT=20: one event, no ACK -> INTR high exactly 21 cycles after PENDING set.
//  4 pulse, WIDTH=3: event -> INTR high 3 cycles then low; new events before ACK -> no second pulse;
//    ACK all -> IDLE; next event -> new pulse.
//  5 EVENT[2] and ACK 0x04 same cycle while PENDING[2]=1 -> PENDING[2] stays 1, OVF[2]=0;
//    EVENT[2] again without ACK -> OVF[2]=1.
//  6 MASK=0, event on bit0 -> PENDING=0x01, INTR=0; RST mid-FIRE -> all outputs at reset values
//    next edge, MASK=C_MASK_RESET.

Source files
------------

// File: rtl/testdrive_interrupt_gen.sv
// Purpose: collects per-source event pulses into pending bits, masks, coalesces and drives INTR.
// Latency: EVENT at edge k sets PENDING at k; with C_COALESCE=1, INTR rises after edge k+1.
// Backpressure: none; events are always accepted, repeats on a pending bit raise OVF instead.
module testdrive_interrupt_gen #(
  parameter int C_SOURCES     = 8,
  parameter int C_COALESCE    = 1,
  parameter int C_TIMEOUT     = 0,
  parameter int C_PULSE_MODE  = 0,
  parameter int C_PULSE_WIDTH = 1,
  parameter logic [C_SOURCES-1:0] C_MASK_RESET = '1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [C_SOURCES-1:0] EVENT,
  input  logic                 MASK_WE,
  input  logic [C_SOURCES-1:0] MASK_WDATA,
  input  logic                 ACK_EN,
  input  logic [C_SOURCES-1:0] ACK_DATA,
  output logic [C_SOURCES-1:0] MASK,
  output logic [C_SOURCES-1:0] PENDING,
  output logic [C_SOURCES-1:0] OVF,
  output logic                 INTR
);

  typedef enum logic [1:0] {IDLE, GATHER, FIRE, WAIT_CLR} state_t;

  localparam logic [7:0]  COAL     = 8'(C_COALESCE);
  localparam logic [15:0] TMO_LAST = 16'(C_TIMEOUT - 1);
  localparam logic [3:0]  PW       = 4'(C_PULSE_WIDTH);

  state_t               state, state_n;
  logic [7:0]           count, count_base, count_n;
  logic [8:0]           count_sum;
  logic [15:0]          timer;
  logic [3:0]           pcnt;
  logic [C_SOURCES-1:0] ackm, epend, newev;
  logic                 enter_idle;

  function automatic logic [5:0] popcnt(input logic [C_SOURCES-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < C_SOURCES; i++) c = c + {5'b0, v[i]};
    return c;
  endfunction

  // Service mask, enabled pending view and newly-counted events; a bit being acked counts as idle.
  always_comb begin
    ackm  = ACK_EN ? ACK_DATA : '0;
    epend = PENDING & MASK;
    newev = EVENT & ~(PENDING & ~ackm) & MASK;
  end

  // Next-state decisions, all taken from registered state, count, timer and epend.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (count >= COAL)      state_n = FIRE;
        else if (epend != '0)   state_n = GATHER;
      end
      GATHER: begin
        if (count >= COAL || (C_TIMEOUT != 0 && timer == TMO_LAST)) state_n = FIRE;
        else if (epend == '0)   state_n = IDLE;
      end
      FIRE: begin
        if (C_PULSE_MODE != 0) begin
          if (pcnt == PW) state_n = (epend == '0) ? IDLE : WAIT_CLR;
        end else if (epend == '0) begin
          state_n = IDLE;
        end
      end
      WAIT_CLR: begin
        if (epend == '0)        state_n = IDLE;
      end
      default:                  state_n = IDLE;
    endcase
  end

  // Coalescing count: cleared on entry to IDLE, yet events of that same cycle still land; saturates.
  always_comb begin
    enter_idle = (state_n == IDLE) && (state != IDLE);
    count_base = enter_idle ? 8'd0 : count;
    count_sum  = {1'b0, count_base} + {3'b0, popcnt(newev)};
    count_n    = (count_sum >= {1'b0, COAL}) ? COAL : count_sum[7:0];
  end

  // Register file, FSM state and the registered interrupt output; reset wins over everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      PENDING <= '0;
      OVF     <= '0;
      MASK    <= C_MASK_RESET;
      INTR    <= 1'b0;
      count   <= '0;
      timer   <= '0;
      pcnt    <= 4'd1;
      state   <= IDLE;
    end else begin
      PENDING <= (PENDING & ~ackm) | EVENT;
      OVF     <= (OVF & ~ackm) | (EVENT & PENDING & ~ackm);
      if (MASK_WE) MASK <= MASK_WDATA;
      count   <= count_n;
      timer   <= (state == GATHER && state_n == GATHER) ? timer + 16'd1 : 16'd0;
      pcnt    <= (state == FIRE) ? pcnt + 4'd1 : 4'd1;
      state   <= state_n;
      INTR    <= (state_n == FIRE);
    end
  end

endmodule

// File: tb/tb_testdrive_interrupt_gen.sv
module tb_testdrive_interrupt_gen;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] ev   [4];
  logic       mwe  [4];
  logic [7:0] mwd  [4];
  logic       acken[4];
  logic [7:0] ackd [4];
  logic [7:0] mask [4];
  logic [7:0] pend [4];
  logic [7:0] ovf  [4];
  logic       intr [4];

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  // Level mode, fire on every new event.
  testdrive_interrupt_gen #(.C_COALESCE(1)) u0 (
    .CLK(CLK), .RST(RST), .EVENT(ev[0]), .MASK_WE(mwe[0]), .MASK_WDATA(mwd[0]),
    .ACK_EN(acken[0]), .ACK_DATA(ackd[0]), .MASK(mask[0]), .PENDING(pend[0]),
    .OVF(ovf[0]), .INTR(intr[0]));

  // Level mode, coalesce four events.
  testdrive_interrupt_gen #(.C_COALESCE(4)) u1 (
    .CLK(CLK), .RST(RST), .EVENT(ev[1]), .MASK_WE(mwe[1]), .MASK_WDATA(mwd[1]),
    .ACK_EN(acken[1]), .ACK_DATA(ackd[1]), .MASK(mask[1]), .PENDING(pend[1]),
    .OVF(ovf[1]), .INTR(intr[1]));

  // Level mode, coalesce eight with a 20-cycle timeout.
  testdrive_interrupt_gen #(.C_COALESCE(8), .C_TIMEOUT(20)) u2 (
    .CLK(CLK), .RST(RST), .EVENT(ev[2]), .MASK_WE(mwe[2]), .MASK_WDATA(mwd[2]),
    .ACK_EN(acken[2]), .ACK_DATA(ackd[2]), .MASK(mask[2]), .PENDING(pend[2]),
    .OVF(ovf[2]), .INTR(intr[2]));

  // Pulse mode, three-cycle pulse.
  testdrive_interrupt_gen #(.C_COALESCE(1), .C_PULSE_MODE(1), .C_PULSE_WIDTH(3)) u3 (
    .CLK(CLK), .RST(RST), .EVENT(ev[3]), .MASK_WE(mwe[3]), .MASK_WDATA(mwd[3]),
    .ACK_EN(acken[3]), .ACK_DATA(ackd[3]), .MASK(mask[3]), .PENDING(pend[3]),
    .OVF(ovf[3]), .INTR(intr[3]));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1;
    for (int d = 0; d < 4; d++) begin
      ev[d] = 8'h00; mwe[d] = 1'b0; mwd[d] = 8'h00; acken[d] = 1'b0; ackd[d] = 8'h00;
    end
    tick(); tick();
    RST = 1'b0;

    // Reset state
    chk("rst_pend", {24'b0, pend[0]}, 32'h00);
    chk("rst_ovf",  {24'b0, ovf[0]},  32'h00);
    chk("rst_mask", {24'b0, mask[0]}, 32'hFF);
    chk("rst_intr", {31'b0, intr[0]}, 32'h0);

    // Test 1: level, coalesce 1
    ev[0] = 8'h01; tick(); ev[0] = 8'h00;
    chk("t1_pend", {24'b0, pend[0]}, 32'h01);
    chk("t1_intr_k", {31'b0, intr[0]}, 32'h0);
    tick();
    chk("t1_intr_k1", {31'b0, intr[0]}, 32'h1);
    acken[0] = 1'b1; ackd[0] = 8'h01; tick(); acken[0] = 1'b0; ackd[0] = 8'h00;
    chk("t1_pend_clr", {24'b0, pend[0]}, 32'h00);
    chk("t1_intr_hold", {31'b0, intr[0]}, 32'h1);
    tick();
    chk("t1_intr_drop", {31'b0, intr[0]}, 32'h0);

    // Test 5: set beats clear, overflow only without ack
    ev[0] = 8'h04; tick();
    chk("t5_pend_set", {24'b0, pend[0]}, 32'h04);
    acken[0] = 1'b1; ackd[0] = 8'h04; tick();
    acken[0] = 1'b0; ackd[0] = 8'h00;
    chk("t5_pend_stay", {24'b0, pend[0]}, 32'h04);
    chk("t5_ovf_none", {24'b0, ovf[0]}, 32'h00);
    tick(); ev[0] = 8'h00;
    chk("t5_ovf_set", {24'b0, ovf[0]}, 32'h04);
    acken[0] = 1'b1; ackd[0] = 8'h04; tick(); acken[0] = 1'b0; ackd[0] = 8'h00;
    chk("t5_ack_pend", {24'b0, pend[0]}, 32'h00);
    chk("t5_ack_ovf", {24'b0, ovf[0]}, 32'h00);
    tick();
    chk("t5_intr_idle", {31'b0, intr[0]}, 32'h0);

    // Masking all pending bits during FIRE drops INTR
    ev[0] = 8'h01; tick(); ev[0] = 8'h00; tick();
    chk("mk_intr_fire", {31'b0, intr[0]}, 32'h1);
    mwe[0] = 1'b1; mwd[0] = 8'h00; tick(); mwe[0] = 1'b0;
    chk("mk_mask0", {24'b0, mask[0]}, 32'h00);
    chk("mk_intr_hold", {31'b0, intr[0]}, 32'h1);
    tick();
    chk("mk_intr_drop", {31'b0, intr[0]}, 32'h0);
    acken[0] = 1'b1; ackd[0] = 8'hFF; tick(); acken[0] = 1'b0; ackd[0] = 8'h00;

    // Test 6: masked event sets PENDING but not INTR
    ev[0] = 8'h01; tick(); ev[0] = 8'h00;
    chk("t6_pend", {24'b0, pend[0]}, 32'h01);
    tick(); tick();
    chk("t6_intr_masked", {31'b0, intr[0]}, 32'h0);
    // Unmasking an already-pending bit must not count as a new event
    mwe[0] = 1'b1; mwd[0] = 8'hFF; tick(); mwe[0] = 1'b0;
    tick(); tick(); tick();
    chk("t6_unmask_nofire", {31'b0, intr[0]}, 32'h0);
    ev[0] = 8'h02; tick(); ev[0] = 8'h00; tick();
    chk("t6_fire", {31'b0, intr[0]}, 32'h1);
    ev[0] = 8'h02; mwe[0] = 1'b1; mwd[0] = 8'h0F; tick();
    ev[0] = 8'h00; mwe[0] = 1'b0;
    chk("t6_mask0f", {24'b0, mask[0]}, 32'h0F);
    chk("t6_ovf1", {24'b0, ovf[0]}, 32'h02);
    chk("t6_still_fire", {31'b0, intr[0]}, 32'h1);
    RST = 1'b1; tick(); RST = 1'b0;
    chk("t6_rst_pend", {24'b0, pend[0]}, 32'h00);
    chk("t6_rst_ovf",  {24'b0, ovf[0]},  32'h00);
    chk("t6_rst_mask", {24'b0, mask[0]}, 32'hFF);
    chk("t6_rst_intr", {31'b0, intr[0]}, 32'h0);

    // Test 2: coalesce 4
    ev[1] = 8'h01; tick(); ev[1] = 8'h02; tick(); ev[1] = 8'h04; tick();
    ev[1] = 8'h01; tick(); ev[1] = 8'h00;
    chk("t2_ovf_dup", {24'b0, ovf[1]}, 32'h01);
    tick(); tick();
    chk("t2_three_nofire", {31'b0, intr[1]}, 32'h0);
    ev[1] = 8'h08; tick(); ev[1] = 8'h00;
    chk("t2_fourth_k", {31'b0, intr[1]}, 32'h0);
    tick();
    chk("t2_fourth_fire", {31'b0, intr[1]}, 32'h1);
    acken[1] = 1'b1; ackd[1] = 8'hFF; tick(); acken[1] = 1'b0; ackd[1] = 8'h00;
    tick();
    chk("t2_cleared", {31'b0, intr[1]}, 32'h0);
    tick();
    ev[1] = 8'h0F; tick(); ev[1] = 8'h00;
    chk("t2_pop_pend", {24'b0, pend[1]}, 32'h0F);
    tick();
    chk("t2_pop_fire", {31'b0, intr[1]}, 32'h1);

    // Test 3: timeout 20
    ev[2] = 8'h01; tick(); ev[2] = 8'h00;
    chk("t3_pend", {24'b0, pend[2]}, 32'h01);
    for (int n = 0; n < 20; n++) tick();
    chk("t3_before_to", {31'b0, intr[2]}, 32'h0);
    tick();
    chk("t3_at_to", {31'b0, intr[2]}, 32'h1);

    // Test 4: pulse width 3
    ev[3] = 8'h01; tick(); ev[3] = 8'h00;
    chk("t4_k", {31'b0, intr[3]}, 32'h0);
    tick(); chk("t4_p1", {31'b0, intr[3]}, 32'h1);
    tick(); chk("t4_p2", {31'b0, intr[3]}, 32'h1);
    tick(); chk("t4_p3", {31'b0, intr[3]}, 32'h1);
    tick(); chk("t4_end", {31'b0, intr[3]}, 32'h0);
    ev[3] = 8'h02; tick(); ev[3] = 8'h00;
    tick(); tick(); tick();
    chk("t4_no_refire", {31'b0, intr[3]}, 32'h0);
    chk("t4_pend_wait", {24'b0, pend[3]}, 32'h03);
    acken[3] = 1'b1; ackd[3] = 8'hFF; tick(); acken[3] = 1'b0; ackd[3] = 8'h00;
    tick(); tick();
    chk("t4_idle_low", {31'b0, intr[3]}, 32'h0);
    ev[3] = 8'h04; tick(); ev[3] = 8'h00;
    tick(); chk("t4_new_p1", {31'b0, intr[3]}, 32'h1);
    tick(); tick(); tick();
    chk("t4_new_end", {31'b0, intr[3]}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
